// File: rtl/memory_arbiter_if.sv
// Requester/memory signal bundle for the two-port memory arbiter.
// slave = arbiter side; master = requesters plus memory model side.
interface memory_arbiter_if #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_SIZE = 16
);
    logic                 req0;
    logic                 req1;
    logic                 we0;
    logic                 we1;
    logic [ADDR_SIZE-1:0] addr0;
    logic [ADDR_SIZE-1:0] addr1;
    logic [WORD_SIZE-1:0] wdata0;
    logic [WORD_SIZE-1:0] wdata1;
    logic                 gnt0;
    logic                 gnt1;
    logic                 rvalid0;
    logic                 rvalid1;
    logic [WORD_SIZE-1:0] rdata0;
    logic [WORD_SIZE-1:0] rdata1;
    logic                 mem_en;
    logic                 mem_we;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic [WORD_SIZE-1:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one single-port memory between CPU (port 0) and DMA (port 1).
// Grant 1 cycle after req from IDLE, read data 1 cycle after grant; requesters hold req until gnt.
module memory_arbiter #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_SIZE = 16,
    parameter int MAX_BURST = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    memory_arbiter_if.slave  bus_if
);
    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

    state_e          state_q, state_d;
    logic            last_owner_q, last_owner_d;
    logic [CW-1:0]   burst_cnt_q, burst_cnt_d;
    logic            rd_vld_q, rd_vld_d;
    logic            rd_port_q, rd_port_d;

    logic                 gnt0, gnt1;
    logic                 mem_en, mem_we;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic                 own_port, own_req, oth_req, own_we;
    logic                 rvalid0, rvalid1;

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        rd_vld_d     = 1'b0;
        rd_port_d    = rd_port_q;
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        own_port     = (state_q == OWN1);
        own_req      = own_port ? bus_if.req1 : bus_if.req0;
        oth_req      = own_port ? bus_if.req0 : bus_if.req1;
        own_we       = own_port ? bus_if.we1  : bus_if.we0;

        case (state_q)
            IDLE: begin
                burst_cnt_d = '0;
                // On a tie the port that did not own the memory last goes first
                if (bus_if.req0 && (!bus_if.req1 || last_owner_q)) begin
                    state_d = OWN0;
                end else if (bus_if.req1) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (own_req) begin
                    gnt0         = ~own_port;
                    gnt1         = own_port;
                    mem_en       = 1'b1;
                    mem_we       = own_we;
                    mem_addr     = own_port ? bus_if.addr1  : bus_if.addr0;
                    mem_wdata    = own_port ? bus_if.wdata1 : bus_if.wdata0;
                    last_owner_d = own_port;
                    rd_vld_d     = ~own_we;
                    rd_port_d    = own_port;
                    if (burst_cnt_q == LAST_CNT) begin
                        // Saturate while the other port is idle; hand over with no gap otherwise
                        if (oth_req) begin
                            state_d     = own_port ? OWN0 : OWN1;
                            burst_cnt_d = '0;
                        end
                    end else begin
                        burst_cnt_d = burst_cnt_q + CW'(1);
                    end
                end else begin
                    burst_cnt_d = '0;
                    state_d     = oth_req ? (own_port ? OWN0 : OWN1) : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (reset_i) begin
            gnt0      = 1'b0;
            gnt1      = 1'b0;
            mem_en    = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            burst_cnt_q  <= '0;
            rd_vld_q     <= 1'b0;
            rd_port_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            rd_vld_q     <= rd_vld_d;
            rd_port_q    <= rd_port_d;
        end
    end

    assign rvalid0 = rd_vld_q & ~rd_port_q & ~reset_i;
    assign rvalid1 = rd_vld_q &  rd_port_q & ~reset_i;

    assign bus_if.gnt0      = gnt0;
    assign bus_if.gnt1      = gnt1;
    assign bus_if.mem_en    = mem_en;
    assign bus_if.mem_we    = mem_we;
    assign bus_if.mem_addr  = mem_addr;
    assign bus_if.mem_wdata = mem_wdata;
    assign bus_if.rvalid0   = rvalid0;
    assign bus_if.rvalid1   = rvalid1;
    assign bus_if.rdata0    = rvalid0 ? bus_if.mem_rdata : '0;
    assign bus_if.rdata1    = rvalid1 ? bus_if.mem_rdata : '0;
endmodule
